collectible_bank: RTL and testbench
===================================

// Module: collectible_bank
// PURPOSE
//   Tracks N_ITEMS collectibles (stars/coins) at fixed world positions; once per frame scans all items
//   against the character box with one shared overlap comparator (one item per clock), retires touched
//   items, pulses a per-hit event, keeps a saturating score and optionally respawns items after a delay.
//   Sits between char physics (char_X/char_Y, bg_pos) and the VGA sprite renderer / score HUD.
// PARAMETERS
//   N_ITEMS        8        number of items; >=1, <=16
//   COORD_W        10       coordinate width
//   ITEM_SIZE      12       item box extent (inclusive edges, as +ITEM_SIZE)
//   CHAR_SIZE      12       character box extent (inclusive edges)
//   SCORE_W        8        score counter width
//   RESPAWN_FRAMES 0        frames until a retired item re-enables; 0 = never respawn
//   ITEM_X_INIT    packed   N_ITEMS*COORD_W world X table, item i at [i*COORD_W +: COORD_W]
//   ITEM_Y_INIT    packed   N_ITEMS*COORD_W world Y table, same packing
// PORTS
//   sys_clk        in   1                system clock
//   RST_N          in   1                async active-low reset
//   frame_tick     in   1                1-cycle pulse, starts a scan
//   char_X         in   COORD_W          character world X
//   char_Y         in   COORD_W          character world Y
//   bg_pos         in   COORD_W          scroll offset
//   rd_idx         in   $clog2(N_ITEMS)  renderer item select
//   rd_x           out  COORD_W          screen X of rd_idx = ITEM_X[rd_idx]-bg_pos (mod 2^COORD_W), comb.
//   rd_y           out  COORD_W          ITEM_Y[rd_idx], comb.
//   rd_en          out  1                enable bit of rd_idx, registered state
//   touch_pulse    out  1                1-cycle pulse per newly touched item
//   touch_idx      out  $clog2(N_ITEMS)  item index valid with touch_pulse
//   score          out  SCORE_W          collected count, saturates at all-ones
//   all_collected  out  1                all enable bits 0
//   scan_busy      out  1                FSM not IDLE
//   overrun        out  1                sticky: frame_tick arrived while busy
// BEHAVIOUR
//   Reset (async, RST_N=0): enable=all 1, state=IDLE, idx=0, touch_pulse=0, touch_idx=0, score=0,
//     overrun=0, respawn counters=0; takes effect mid-scan, scan abandoned, no pulse after release.
//   FSM IDLE -> SCAN on frame_tick; char_X/char_Y latched that edge, used for whole scan.
//   SCAN: item idx tested per cycle, idx 0..N_ITEMS-1; after last item -> DONE (1 cycle) -> IDLE.
//     Scan latency N_ITEMS+1 cycles from frame_tick to scan_busy=0; next tick accepted in IDLE only.
//   Overlap (inclusive, computed at COORD_W+1 bits, no wrap): cx<=ix+ITEM_SIZE && ix<=cx+CHAR_SIZE
//     && cy<=iy+ITEM_SIZE && iy<=cy+CHAR_SIZE.
//   Hit on enabled item: next edge enable[idx]=0, touch_pulse=1, touch_idx=idx, score+=1 (sat),
//     respawn cnt[idx]=RESPAWN_FRAMES. Disabled items never hit. Multiple hits in one scan -> one
//     pulse per item in consecutive/ascending cycles.
//   Respawn (RESPAWN_FRAMES>0): on frame_tick each nonzero cnt decrements; 1->0 sets enable=1 same
//     edge. Item retired this frame is not re-tested until next frame. RESPAWN_FRAMES=0: no counters.
//   frame_tick while busy: ignored, overrun<=1 until reset.
//   rd_x wraps modulo 2^COORD_W (off-screen handled by renderer); rd_idx>=N_ITEMS -> rd_en=0.
//   all_collected combinational from enable vector.
// STRUCTURE
//   Package game_pkg: COORD_W, SCORE_W, scan state enum {IDLE,SCAN,DONE}, aabb width helpers.
//   Sub-module aabb_overlap (comb, parameters COORD_W/ITEM_SIZE/CHAR_SIZE): single shared comparator.
//   Top holds FSM, idx counter, enable vector, respawn counter array, score.
// TESTING
//   Reset, N=4, item0 at (100,306); char (95,300), tick -> pulse at cycle 1, touch_idx=0, score=1, rd_en(0)=0.
//   Same char, next tick -> no pulse, score stays 1.
//   Items 1,3 both overlapping char -> pulses cycles 2,4, idx 1 then 3, score +2; all 4 hit -> all_collected=1.
//   Edge: char_X=ix+12 -> hit; char_X=ix+13 -> no hit; ix=0, char_X=1020 -> no hit (no wrap).
//   SCORE_W=2 -> score saturates 3; RESPAWN_FRAMES=2 -> item re-enabled on 2nd tick after hit.
//   Tick mid-scan -> overrun=1, scan unaffected; RST_N low mid-scan -> all outputs reset values, enable all 1.

Source files
------------

// File: rtl/collectible_bank_pkg.sv
// Shared types and width helpers for the collectible bank: scan FSM states,
// default widths and the derived index/counter/compare widths.
package collectible_bank_pkg;

   localparam int COORD_W_DEF = 10;
   localparam int SCORE_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_e;

   // One extra bit so box edges near the top of the coordinate range never wrap.
   function automatic int aabb_w(input int coord_w);
      return coord_w + 1;
   endfunction

   function automatic int idx_w(input int n_items);
      return (n_items > 1) ? $clog2(n_items) : 1;
   endfunction

   function automatic int cnt_w(input int frames);
      return (frames > 0) ? $clog2(frames + 1) : 1;
   endfunction

endpackage

// File: rtl/collectible_bank_aabb_overlap.sv
// Shared inclusive box-overlap comparator between the character box and one item box.
module collectible_bank_aabb_overlap
   import collectible_bank_pkg::*;
#(
   parameter int COORD_W   = COORD_W_DEF,
   parameter int ITEM_SIZE = 12,
   parameter int CHAR_SIZE = 12
) (
   input  logic [COORD_W-1:0] cx_i,
   input  logic [COORD_W-1:0] cy_i,
   input  logic [COORD_W-1:0] ix_i,
   input  logic [COORD_W-1:0] iy_i,
   output logic               hit_o
);

   localparam int AW = aabb_w(COORD_W);

   logic [AW-1:0] cx, cy, ix, iy;
   logic          x_ovl, y_ovl;

   assign cx = AW'(cx_i);
   assign cy = AW'(cy_i);
   assign ix = AW'(ix_i);
   assign iy = AW'(iy_i);

   assign x_ovl = (cx <= ix + AW'(ITEM_SIZE)) && (ix <= cx + AW'(CHAR_SIZE));
   assign y_ovl = (cy <= iy + AW'(ITEM_SIZE)) && (iy <= cy + AW'(CHAR_SIZE));
   assign hit_o = x_ovl && y_ovl;

endmodule

// File: rtl/collectible_bank.sv
// Collectible item bank: per-frame sequential scan of all items against the character box,
// retiring touched items, pulsing per-hit events, saturating score and optional respawn.
module collectible_bank
   import collectible_bank_pkg::*;
#(
   parameter int                         N_ITEMS        = 8,
   parameter int                         COORD_W        = COORD_W_DEF,
   parameter int                         ITEM_SIZE      = 12,
   parameter int                         CHAR_SIZE      = 12,
   parameter int                         SCORE_W        = SCORE_W_DEF,
   parameter int                         RESPAWN_FRAMES = 0,
   parameter logic [N_ITEMS*COORD_W-1:0] ITEM_X_INIT    = '0,
   parameter logic [N_ITEMS*COORD_W-1:0] ITEM_Y_INIT    = '0
) (
   input  logic                         sys_clk,
   input  logic                         RST_N,
   input  logic                         frame_tick,
   input  logic [COORD_W-1:0]           char_X,
   input  logic [COORD_W-1:0]           char_Y,
   input  logic [COORD_W-1:0]           bg_pos,
   input  logic [idx_w(N_ITEMS)-1:0]    rd_idx,
   output logic [COORD_W-1:0]           rd_x,
   output logic [COORD_W-1:0]           rd_y,
   output logic                         rd_en,
   output logic                         touch_pulse,
   output logic [idx_w(N_ITEMS)-1:0]    touch_idx,
   output logic [SCORE_W-1:0]           score,
   output logic                         all_collected,
   output logic                         scan_busy,
   output logic                         overrun
);

   localparam int                IDX_W    = idx_w(N_ITEMS);
   localparam int                N_PAD    = 1 << IDX_W;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_ITEMS - 1);

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      if (&v) return v;
      return v + SCORE_W'(1);
   endfunction

   scan_state_e          state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [N_ITEMS-1:0]   en_q, en_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic                 pulse_q, pulse_d;
   logic [IDX_W-1:0]     tidx_q, tidx_d;
   logic                 ovr_q, ovr_d;
   logic [COORD_W-1:0]   cx_q, cy_q;

   logic                 accept;
   logic                 ovl_hit;
   logic                 hit_en;
   logic [N_ITEMS-1:0]   hit_onehot;
   logic [N_ITEMS-1:0]   respawn;
   logic [N_PAD-1:0]     en_pad;
   logic [COORD_W-1:0]   item_x [N_PAD];
   logic [COORD_W-1:0]   item_y [N_PAD];

   // Tables padded to a power of two so any index value selects a defined entry.
   for (genvar g = 0; g < N_PAD; g++) begin : g_tbl
      if (g < N_ITEMS) begin : g_item
         assign item_x[g] = ITEM_X_INIT[g*COORD_W +: COORD_W];
         assign item_y[g] = ITEM_Y_INIT[g*COORD_W +: COORD_W];
      end else begin : g_pad
         assign item_x[g] = '0;
         assign item_y[g] = '0;
      end
   end

   assign en_pad = N_PAD'(en_q);
   assign accept = frame_tick && (state_q == IDLE);

   collectible_bank_aabb_overlap #(
      .COORD_W   (COORD_W),
      .ITEM_SIZE (ITEM_SIZE),
      .CHAR_SIZE (CHAR_SIZE)
   ) u_overlap (
      .cx_i  (cx_q),
      .cy_i  (cy_q),
      .ix_i  (item_x[idx_q]),
      .iy_i  (item_y[idx_q]),
      .hit_o (ovl_hit)
   );

   assign hit_en = (state_q == SCAN) && ovl_hit && en_pad[idx_q];

   always_comb begin
      hit_onehot = '0;
      for (int i = 0; i < N_ITEMS; i++) begin
         hit_onehot[i] = hit_en && (idx_q == IDX_W'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (frame_tick) begin
               state_d = SCAN;
               idx_d   = '0;
            end
         end
         SCAN: begin
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Hits only occur mid-scan and respawns only on an accepted tick, so they never collide.
   always_comb begin
      en_d    = (en_q | respawn) & ~hit_onehot;
      pulse_d = hit_en;
      tidx_d  = hit_en ? idx_q : tidx_q;
      score_d = hit_en ? sat_inc(score_q) : score_q;
      ovr_d   = ovr_q | (frame_tick && (state_q != IDLE));
   end

   always_ff @(posedge sys_clk or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         idx_q   <= '0;
         en_q    <= '1;
         score_q <= '0;
         pulse_q <= 1'b0;
         tidx_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         en_q    <= en_d;
         score_q <= score_d;
         pulse_q <= pulse_d;
         tidx_q  <= tidx_d;
         ovr_q   <= ovr_d;
      end
   end

   // Character position is frozen for the whole scan.
   always_ff @(posedge sys_clk) begin
      if (accept) begin
         cx_q <= char_X;
         cy_q <= char_Y;
      end
   end

   if (RESPAWN_FRAMES > 0) begin : g_respawn
      localparam int CNT_W = cnt_w(RESPAWN_FRAMES);
      for (genvar g = 0; g < N_ITEMS; g++) begin : g_cnt
         logic [CNT_W-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (hit_onehot[g]) begin
               cnt_d = CNT_W'(RESPAWN_FRAMES);
            end else if (accept && (cnt_q != '0)) begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         always_ff @(posedge sys_clk or negedge RST_N) begin
            if (!RST_N) cnt_q <= '0;
            else        cnt_q <= cnt_d;
         end

         assign respawn[g] = accept && (cnt_q == CNT_W'(1));
      end
   end else begin : g_no_respawn
      assign respawn = '0;
   end

   assign rd_x          = item_x[rd_idx] - bg_pos;
   assign rd_y          = item_y[rd_idx];
   assign rd_en         = en_pad[rd_idx];
   assign touch_pulse   = pulse_q;
   assign touch_idx     = tidx_q;
   assign score         = score_q;
   assign all_collected = ~|en_q;
   assign scan_busy     = (state_q != IDLE);
   assign overrun       = ovr_q;

endmodule

// File: tb/tb_collectible_bank.sv
// Scoreboard bench for collectible_bank: two instances (plain and saturating/respawning)
// driven by directed and random frames, checked against a frame-level reference model.
module tb_collectible_bank;

   localparam int N  = 4;
   localparam int CW = 10;
   localparam logic [N*CW-1:0] XT = {10'd405, 10'd0, 10'd400, 10'd100};
   localparam logic [N*CW-1:0] YT = {10'd105, 10'd500, 10'd100, 10'd306};

   int X[N] = '{100, 400, 0, 405};
   int Y[N] = '{306, 100, 500, 105};

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          tick = 1'b0;
   logic [CW-1:0] cx = '0, cy = '0, bg = '0;
   logic [1:0]    ridx = '0;

   logic [CW-1:0] rdxA, rdyA, rdxB, rdyB;
   logic          rdenA, rdenB, tpA, tpB, allA, allB, busyA, busyB, ovrA, ovrB;
   logic [1:0]    tidxA, tidxB;
   logic [7:0]    scA;
   logic [1:0]    scB;

   collectible_bank #(
      .N_ITEMS(N), .COORD_W(CW), .ITEM_SIZE(12), .CHAR_SIZE(12), .SCORE_W(8),
      .RESPAWN_FRAMES(0), .ITEM_X_INIT(XT), .ITEM_Y_INIT(YT)
   ) u_a (
      .sys_clk(clk), .RST_N(rst_n), .frame_tick(tick), .char_X(cx), .char_Y(cy),
      .bg_pos(bg), .rd_idx(ridx), .rd_x(rdxA), .rd_y(rdyA), .rd_en(rdenA),
      .touch_pulse(tpA), .touch_idx(tidxA), .score(scA), .all_collected(allA),
      .scan_busy(busyA), .overrun(ovrA)
   );

   collectible_bank #(
      .N_ITEMS(N), .COORD_W(CW), .ITEM_SIZE(12), .CHAR_SIZE(12), .SCORE_W(2),
      .RESPAWN_FRAMES(2), .ITEM_X_INIT(XT), .ITEM_Y_INIT(YT)
   ) u_b (
      .sys_clk(clk), .RST_N(rst_n), .frame_tick(tick), .char_X(cx), .char_Y(cy),
      .bg_pos(bg), .rd_idx(ridx), .rd_x(rdxB), .rd_y(rdyB), .rd_en(rdenB),
      .touch_pulse(tpB), .touch_idx(tidxB), .score(scB), .all_collected(allB),
      .scan_busy(busyB), .overrun(ovrB)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int idx;
      int cyc;
      int score;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: per-instance enables, respawn counts and scores
   int en[2][N];
   int cnt[2][N];
   int sc[2];
   int RF[2]   = '{0, 2};
   int SMAX[2] = '{255, 3};
   int ovr;

   function automatic bit touches(input int cxv, input int cyv, input int i);
      return (cxv <= X[i] + 12) && (X[i] <= cxv + 12) && (cyv <= Y[i] + 12) && (Y[i] <= cyv + 12);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         sc[d] = 0;
         for (int i = 0; i < N; i++) begin
            en[d][i]  = 1;
            cnt[d][i] = 0;
         end
      end
      ovr = 0;
   endtask

   task automatic model_frame(input int cxv, input int cyv, input int base);
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < N; i++) begin
            if (cnt[d][i] > 0) begin
               cnt[d][i]--;
               if (cnt[d][i] == 0) en[d][i] = 1;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (en[d][i] == 1 && touches(cxv, cyv, i)) begin
               en[d][i]  = 0;
               cnt[d][i] = RF[d];
               if (sc[d] < SMAX[d]) sc[d]++;
               e.idx   = i;
               e.cyc   = base + i;
               e.score = sc[d];
               if (d == 0) qa.push_back(e);
               else        qb.push_back(e);
            end
         end
      end
   endtask

   // Monitor: every pulse must match the head of its queue; overdue entries are misses
   always @(negedge clk) begin
      if (tpA) begin
         if (qa.size() == 0) begin
            chk("pulseA_unexpected", 1, 0);
         end else begin
            ea = qa.pop_front();
            chk("touch_idxA", tidxA, ea.idx);
            chk("pulse_cycA", cyc, ea.cyc);
            chk("pulse_scoreA", scA, ea.score);
         end
      end else if (qa.size() > 0 && qa[0].cyc <= cyc) begin
         ea = qa.pop_front();
         chk("pulseA_missing", 0, 1);
      end
      if (tpB) begin
         if (qb.size() == 0) begin
            chk("pulseB_unexpected", 1, 0);
         end else begin
            eb = qb.pop_front();
            chk("touch_idxB", tidxB, eb.idx);
            chk("pulse_cycB", cyc, eb.cyc);
            chk("pulse_scoreB", scB, eb.score);
         end
      end else if (qb.size() > 0 && qb[0].cyc <= cyc) begin
         eb = qb.pop_front();
         chk("pulseB_missing", 0, 1);
      end
   end

   task automatic check_state(input string tag);
      int bgv;
      int allm[2];
      for (int d = 0; d < 2; d++) begin
         allm[d] = 1;
         for (int i = 0; i < N; i++) if (en[d][i] == 1) allm[d] = 0;
      end
      for (int i = 0; i < N; i++) begin
         bgv  = $urandom_range(0, 1023);
         bg   = 10'(bgv);
         ridx = 2'(i);
         #1;
         chk({tag, "_rd_enA"}, rdenA, en[0][i]);
         chk({tag, "_rd_enB"}, rdenB, en[1][i]);
         chk({tag, "_rd_x"}, rdxA, ((X[i] - bgv) % 1024 + 1024) % 1024);
         chk({tag, "_rd_y"}, rdyB, Y[i]);
      end
      chk({tag, "_scoreA"}, scA, sc[0]);
      chk({tag, "_scoreB"}, scB, sc[1]);
      chk({tag, "_allA"}, allA, allm[0]);
      chk({tag, "_allB"}, allB, allm[1]);
      chk({tag, "_overrunA"}, ovrA, ovr);
      chk({tag, "_overrunB"}, ovrB, ovr);
      chk({tag, "_busy"}, busyA, 0);
   endtask

   task automatic frame(input int cxv, input int cyv, input bit extra);
      int c0;
      @(negedge clk);
      c0   = cyc;
      cx   = 10'(cxv);
      cy   = 10'(cyv);
      tick = 1'b1;
      model_frame(cxv, cyv, c0 + 2);
      @(negedge clk);
      tick = 1'b0;
      chk("busy_start", busyA, 1);
      for (int k = 1; k <= N; k++) begin
         @(negedge clk);
         cx   = 10'($urandom_range(0, 1023));
         cy   = 10'($urandom_range(0, 1023));
         tick = extra && (k == 1);
         if (extra && k == 1) ovr = 1;
      end
      chk("busy_last", busyB, 1);
      @(negedge clk);
      chk("busy_end", busyA, 0);
   endtask

   task automatic reset_mid_scan();
      @(negedge clk);
      cx   = 10'd415;
      cy   = 10'd115;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      qa.delete();
      qb.delete();
      model_reset();
      #1;
      chk("rst_touchA", tpA, 0);
      chk("rst_tidxB", tidxB, 0);
      check_state("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check_state("rst_after");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int j, xv, yv;
      model_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_touch", tpA, 0);
      chk("reset_tidx", tidxA, 0);
      check_state("reset");
      rst_n = 1'b1;

      frame(95, 300, 0);      check_state("first_hit");
      frame(95, 300, 0);      check_state("repeat_tick");
      frame(402, 102, 0);     check_state("double_hit");
      frame(1020, 500, 0);    check_state("no_wrap");
      frame(13, 500, 0);      check_state("edge_out");
      frame(12, 500, 0);      check_state("edge_in");
      frame(95, 300, 1);      check_state("overrun");

      reset_mid_scan();

      for (int f = 0; f < 40; f++) begin
         j  = $urandom_range(0, N - 1);
         xv = X[j] + int'($urandom_range(0, 32)) - 16;
         yv = Y[j] + int'($urandom_range(0, 32)) - 16;
         if (xv < 0) xv = 0;
         if (yv < 0) yv = 0;
         frame(xv, yv, (f % 13) == 12);
         check_state("random");
      end

      repeat (5) @(negedge clk);
      chk("drainA", qa.size(), 0);
      chk("drainB", qb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
